// File: rtl/pixel_arr_sync_model.sv
// Clocked model of a ROWS x COLS ON/OFF event-pixel array with row/column AER outputs,
// delayed column acknowledges, per-latch refractory timers and a saturating drop counter.
module pixel_arr_sync_model #(
    parameter int ROWS       = 12,
    parameter int COLS       = 16,
    parameter int DEL_CYC    = 2,
    parameter int REFRAC_CYC = 4,
    parameter int CLR_SPLIT  = 0,
    parameter int DROP_W     = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [ROWS*COLS-1:0]   i_spk_in_on,
    input  logic [ROWS*COLS-1:0]   i_spk_in_off,
    input  logic [ROWS-1:0]        i_s,
    input  logic [COLS-1:0]        i_cix_on,
    input  logic [COLS-1:0]        i_cix_off,
    output logic [ROWS-1:0]        o_n_p,
    output logic [COLS-1:0]        o_n_cox_on,
    output logic [COLS-1:0]        o_n_cox_off,
    output logic [COLS-1:0]        o_cix_on_del,
    output logic [COLS-1:0]        o_cix_off_del,
    output logic [DROP_W-1:0]      o_drop_cnt
);

    localparam int NPIX = ROWS * COLS;
    localparam int RW   = (REFRAC_CYC > 0) ? $clog2(REFRAC_CYC + 1) : 1;
    localparam int CW   = $clog2(2 * NPIX + 1);
    localparam int SW   = ((DROP_W > CW) ? DROP_W : CW) + 1;
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic [COLS-1:0]   r_dly_on  [DEL_CYC];
    logic [COLS-1:0]   r_dly_off [DEL_CYC];
    logic [NPIX-1:0]   r_lat_on;
    logic [NPIX-1:0]   r_lat_off;
    logic [RW-1:0]     r_ref_on  [NPIX];
    logic [RW-1:0]     r_ref_off [NPIX];
    logic [DROP_W-1:0] r_drop_cnt;

    logic [COLS-1:0]   w_pon;
    logic [COLS-1:0]   w_poff;
    logic [NPIX-1:0]   w_clr_on;
    logic [NPIX-1:0]   w_clr_off;
    logic [NPIX-1:0]   w_ref_on;
    logic [NPIX-1:0]   w_ref_off;
    logic [NPIX-1:0]   w_drop_on;
    logic [NPIX-1:0]   w_drop_off;
    logic [CW-1:0]     w_drop_sum;
    logic [SW-1:0]     w_drop_ext;
    logic [DROP_W-1:0] w_drop_nxt;
    logic [COLS-1:0]   w_cox_on;
    logic [COLS-1:0]   w_cox_off;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DEL_CYC; k++) begin
                r_dly_on[k]  <= '0;
                r_dly_off[k] <= '0;
            end
        end else begin
            r_dly_on[0]  <= i_cix_on;
            r_dly_off[0] <= i_cix_off;
            for (int k = 1; k < DEL_CYC; k++) begin
                r_dly_on[k]  <= r_dly_on[k-1];
                r_dly_off[k] <= r_dly_off[k-1];
            end
        end
    end

    assign o_cix_on_del  = r_dly_on[DEL_CYC-1];
    assign o_cix_off_del = r_dly_off[DEL_CYC-1];
    // Clear pulse is the part of cix not yet seen at the delayed tap.
    assign w_pon  = i_cix_on  & ~o_cix_on_del;
    assign w_poff = i_cix_off & ~o_cix_off_del;

    always_comb begin
        w_clr_on   = '0;
        w_clr_off  = '0;
        w_ref_on   = '0;
        w_ref_off  = '0;
        w_drop_sum = '0;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                if (CLR_SPLIT != 0) begin
                    w_clr_on[y*COLS+x]  = i_s[y] & w_pon[x];
                    w_clr_off[y*COLS+x] = i_s[y] & w_poff[x];
                end else begin
                    w_clr_on[y*COLS+x]  = i_s[y] & (w_pon[x] | w_poff[x]);
                    w_clr_off[y*COLS+x] = i_s[y] & (w_pon[x] | w_poff[x]);
                end
                w_ref_on[y*COLS+x]  = (r_ref_on[y*COLS+x]  != '0);
                w_ref_off[y*COLS+x] = (r_ref_off[y*COLS+x] != '0);
            end
        end
        w_drop_on  = i_spk_in_on  & (w_clr_on  | w_ref_on  | r_lat_on);
        w_drop_off = i_spk_in_off & (w_clr_off | w_ref_off | r_lat_off);
        for (int i = 0; i < NPIX; i++) begin
            w_drop_sum = w_drop_sum + CW'(w_drop_on[i]) + CW'(w_drop_off[i]);
        end
    end

    assign w_drop_ext = SW'(r_drop_cnt) + SW'(w_drop_sum);
    assign w_drop_nxt = (w_drop_ext > SW'(DROP_MAX)) ? DROP_MAX : w_drop_ext[DROP_W-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lat_on   <= '0;
            r_lat_off  <= '0;
            r_drop_cnt <= '0;
            for (int i = 0; i < NPIX; i++) begin
                r_ref_on[i]  <= '0;
                r_ref_off[i] <= '0;
            end
        end else begin
            r_drop_cnt <= w_drop_nxt;
            for (int i = 0; i < NPIX; i++) begin
                if (w_clr_on[i]) begin
                    r_lat_on[i] <= 1'b0;
                    r_ref_on[i] <= RW'(REFRAC_CYC);
                end else if (w_ref_on[i]) begin
                    r_ref_on[i] <= r_ref_on[i] - RW'(1);
                end else if (i_spk_in_on[i]) begin
                    r_lat_on[i] <= 1'b1;
                end
                if (w_clr_off[i]) begin
                    r_lat_off[i] <= 1'b0;
                    r_ref_off[i] <= RW'(REFRAC_CYC);
                end else if (w_ref_off[i]) begin
                    r_ref_off[i] <= r_ref_off[i] - RW'(1);
                end else if (i_spk_in_off[i]) begin
                    r_lat_off[i] <= 1'b1;
                end
            end
        end
    end

    // Outputs depend only on latch flops and s, never directly on spike inputs.
    always_comb begin
        w_cox_on  = '0;
        w_cox_off = '0;
        for (int y = 0; y < ROWS; y++) begin
            o_n_p[y] = ~|(r_lat_on[y*COLS +: COLS] | r_lat_off[y*COLS +: COLS]);
            for (int x = 0; x < COLS; x++) begin
                w_cox_on[x]  = w_cox_on[x]  | (r_lat_on[y*COLS+x]  & i_s[y]);
                w_cox_off[x] = w_cox_off[x] | (r_lat_off[y*COLS+x] & i_s[y]);
            end
        end
    end

    assign o_n_cox_on  = ~w_cox_on;
    assign o_n_cox_off = ~w_cox_off;
    assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_pixel_arr_sync_model.sv
// Bench for pixel_arr_sync_model: two instances (merged and split clear) driven identically,
// checked against an array/queue reference model plus directed boundary checks.
module tb_pixel_arr_sync_model;

    localparam int R = 12;
    localparam int C = 16;
    localparam int N = R * C;
    localparam int DEL = 2;
    localparam int REF = 4;
    localparam int DMAX = 65535;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] spk_on, spk_off;
    logic [R-1:0] s;
    logic [C-1:0] con, coff;

    logic [R-1:0]  np    [2];
    logic [C-1:0]  cxon  [2];
    logic [C-1:0]  cxoff [2];
    logic [C-1:0]  don   [2];
    logic [C-1:0]  doff  [2];
    logic [15:0]   drop  [2];

    pixel_arr_sync_model #(.ROWS(R), .COLS(C), .DEL_CYC(DEL), .REFRAC_CYC(REF),
                           .CLR_SPLIT(0), .DROP_W(16)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_spk_in_on(spk_on), .i_spk_in_off(spk_off),
        .i_s(s), .i_cix_on(con), .i_cix_off(coff), .o_n_p(np[0]),
        .o_n_cox_on(cxon[0]), .o_n_cox_off(cxoff[0]), .o_cix_on_del(don[0]),
        .o_cix_off_del(doff[0]), .o_drop_cnt(drop[0]));

    pixel_arr_sync_model #(.ROWS(R), .COLS(C), .DEL_CYC(DEL), .REFRAC_CYC(REF),
                           .CLR_SPLIT(1), .DROP_W(16)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_spk_in_on(spk_on), .i_spk_in_off(spk_off),
        .i_s(s), .i_cix_on(con), .i_cix_off(coff), .o_n_p(np[1]),
        .o_n_cox_on(cxon[1]), .o_n_cox_off(cxoff[1]), .o_cix_on_del(don[1]),
        .o_cix_off_del(doff[1]), .o_drop_cnt(drop[1]));

    bit m_on   [2][N];
    bit m_off  [2][N];
    int m_ron  [2][N];
    int m_roff [2][N];
    int m_drop [2];
    logic [C-1:0] q_on[$];
    logic [C-1:0] q_off[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_drop[k] = 0;
            for (int i = 0; i < N; i++) begin
                m_on[k][i] = 0; m_off[k][i] = 0; m_ron[k][i] = 0; m_roff[k][i] = 0;
            end
        end
        q_on.delete();
        q_off.delete();
        for (int d = 0; d < DEL; d++) begin
            q_on.push_back('0);
            q_off.push_back('0);
        end
    endtask

    task automatic upd(input bit clr, input bit spk, input bit lat_i, input int rf_i,
                       output bit lat_o, output int rf_o, output int dropped);
        lat_o = lat_i; rf_o = rf_i; dropped = 0;
        if (clr) begin
            lat_o = 0; rf_o = REF; dropped = spk;
        end else if (rf_i > 0) begin
            rf_o = rf_i - 1; dropped = spk;
        end else if (spk) begin
            if (lat_i) dropped = 1;
            else lat_o = 1;
        end
    endtask

    task automatic model_step();
        logic [C-1:0] pon, poff;
        bit c_on, c_off, l;
        int rf, d, n, i;
        pon  = con  & ~q_on[0];
        poff = coff & ~q_off[0];
        for (int k = 0; k < 2; k++) begin
            n = 0;
            for (int y = 0; y < R; y++) begin
                for (int x = 0; x < C; x++) begin
                    i = y * C + x;
                    if (k == 1) begin
                        c_on = s[y] & pon[x]; c_off = s[y] & poff[x];
                    end else begin
                        c_on = s[y] & (pon[x] | poff[x]); c_off = c_on;
                    end
                    upd(c_on, spk_on[i], m_on[k][i], m_ron[k][i], l, rf, d);
                    m_on[k][i] = l; m_ron[k][i] = rf; n += d;
                    upd(c_off, spk_off[i], m_off[k][i], m_roff[k][i], l, rf, d);
                    m_off[k][i] = l; m_roff[k][i] = rf; n += d;
                end
            end
            m_drop[k] = (m_drop[k] + n > DMAX) ? DMAX : m_drop[k] + n;
        end
        q_on.push_back(con);   void'(q_on.pop_front());
        q_off.push_back(coff); void'(q_off.pop_front());
    endtask

    task automatic check_all();
        logic [R-1:0] enp;
        logic [C-1:0] eon, eoff;
        bit any;
        for (int k = 0; k < 2; k++) begin
            for (int y = 0; y < R; y++) begin
                any = 0;
                for (int x = 0; x < C; x++) any |= m_on[k][y*C+x] | m_off[k][y*C+x];
                enp[y] = !any;
            end
            for (int x = 0; x < C; x++) begin
                eon[x] = 1; eoff[x] = 1;
                for (int y = 0; y < R; y++) begin
                    if (s[y] && m_on[k][y*C+x])  eon[x] = 0;
                    if (s[y] && m_off[k][y*C+x]) eoff[x] = 0;
                end
            end
            chk($sformatf("n_p%0d", k), 64'(np[k]), 64'(enp));
            chk($sformatf("n_cox_on%0d", k), 64'(cxon[k]), 64'(eon));
            chk($sformatf("n_cox_off%0d", k), 64'(cxoff[k]), 64'(eoff));
            chk($sformatf("cix_on_del%0d", k), 64'(don[k]), 64'(q_on[0]));
            chk($sformatf("cix_off_del%0d", k), 64'(doff[k]), 64'(q_off[0]));
            chk($sformatf("drop_cnt%0d", k), 64'(drop[k]), 64'(m_drop[k]));
        end
    endtask

    task automatic drive(input logic [N-1:0] a_on, input logic [N-1:0] a_off,
                         input logic [R-1:0] a_s, input logic [C-1:0] a_con,
                         input logic [C-1:0] a_coff);
        @(negedge clk);
        spk_on = a_on; spk_off = a_off; s = a_s; con = a_con; coff = a_coff;
        #1;
        check_all();
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        spk_on = '0; spk_off = '0; s = '1; con = '0; coff = '0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            chk("rst_n_p", 64'(np[k]), 64'hfff);
            chk("rst_cox_on", 64'(cxon[k]), 64'hffff);
            chk("rst_cox_off", 64'(cxoff[k]), 64'hffff);
            chk("rst_drop", 64'(drop[k]), 64'h0);
            chk("rst_del", 64'({don[k], doff[k]}), 64'h0);
        end
        #2 rst_n = 1'b1;
    endtask

    function automatic logic [N-1:0] rvec(input int odds);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, odds - 1) == 0);
        return v;
    endfunction

    logic [N-1:0] b35, b0, b1, allv;

    initial begin
        spk_on = '0; spk_off = '0; s = '0; con = '0; coff = '0;
        b35 = '0; b35[3*C+5] = 1'b1;
        b0 = '0;  b0[0] = 1'b1;
        b1 = '0;  b1[1] = 1'b1;
        allv = '1;
        model_reset();
        #12;
        do_reset();

        // Spike, select, delayed ack, refractory window.
        drive(b35, '0, '0, '0, '0); step();
        drive('0, '0, 12'h008, '0, '0);
        chk("spk_np3", 64'(np[0][3]), 64'h0);
        chk("spk_cox_on5", 64'(cxon[0][5]), 64'h0);
        chk("spk_cox_off", 64'(cxoff[0]), 64'hffff);
        step();
        drive('0, '0, 12'h008, 16'h0020, '0);
        chk("del_early", 64'(don[0][5]), 64'h0);
        step();
        drive('0, '0, 12'h008, 16'h0020, '0);
        chk("clr_np3", 64'(np[0][3]), 64'h1);
        step();
        for (int j = 0; j < REF; j++) begin
            drive(b35, '0, 12'h008, 16'h0020, '0);
            if (j == 0) chk("del_on5", 64'(don[0][5]), 64'h1);
            step();
        end
        drive(b35, '0, 12'h008, 16'h0020, '0);
        chk("refrac_drops", 64'(drop[0]), 64'd4);
        step();
        drive('0, '0, 12'h008, 16'h0020, '0);
        chk("relatch_np3", 64'(np[0][3]), 64'h0);
        chk("relatch_drop", 64'(drop[0]), 64'd4);
        step();

        // Drop on already-set latch and during clear cycle.
        do_reset();
        drive(b1, '0, '0, '0, '0); step();
        drive(b1, '0, '0, '0, '0); step();
        drive(b1, '0, 12'h001, 16'h0002, '0); step();
        drive('0, '0, '0, '0, '0);
        chk("drop_set_clr", 64'(drop[0]), 64'd2);
        step();

        // Polarity-selective clear.
        do_reset();
        drive(b0, b0, '0, '0, '0); step();
        drive('0, '0, 12'h001, '0, 16'h0001); step();
        drive('0, '0, 12'h001, '0, 16'h0001);
        chk("split_np0", 64'(np[1][0]), 64'h0);
        chk("split_cox_on0", 64'(cxon[1][0]), 64'h0);
        chk("split_cox_off0", 64'(cxoff[1][0]), 64'h1);
        chk("merge_np0", 64'(np[0][0]), 64'h1);
        step();
        for (int j = 0; j < 3; j++) begin drive('0, '0, '0, '0, '0); step(); end

        // Saturation of the drop counter.
        do_reset();
        for (int j = 0; j < 180; j++) begin drive(allv, allv, '0, '0, '0); step(); end
        drive(allv, allv, '0, '0, '0);
        chk("sat0", 64'(drop[0]), 64'hffff);
        chk("sat1", 64'(drop[1]), 64'hffff);
        step();
        drive(allv, allv, '0, '0, '0);
        chk("sat_hold", 64'(drop[0]), 64'hffff);
        step();

        // Randomised traffic with a mid-run reset.
        do_reset();
        for (int j = 0; j < 600; j++) begin
            logic [C-1:0] ton, toff;
            if (j == 300) do_reset();
            ton = '0; toff = '0;
            for (int x = 0; x < C; x++) begin
                ton[x]  = ($urandom_range(0, 3) == 0);
                toff[x] = ($urandom_range(0, 3) == 0);
            end
            drive(rvec(8), rvec(8), R'($urandom), con ^ ton, coff ^ toff);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
